// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, states,
// ALU/mux select codes and the packed control word.
package mc_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_ADDIEX = 4'd11,
        ST_ADDIWB = 4'd12,
        ST_EXC    = 4'd13
    } state_t;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] PCSRC_EXC    = 2'b11;

    typedef struct packed {
        logic             pcWrite;
        logic             pcWriteCond;
        logic             iorD;
        logic             memRead;
        logic             memWrite;
        logic             irWrite;
        logic             memToReg;
        logic             regDst;
        logic             regWrite;
        logic             aluSrcA;
        logic [SEL_W-1:0] aluSrcB;
        logic [SEL_W-1:0] aluOp;
        logic [SEL_W-1:0] pcSource;
    } ctrl_t;

    function automatic logic isMemOp(input logic [OPCODE_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_out_decode.sv
// Pure combinational state + memReady -> control word decoder.
// MULTICYCLE_CTRL_EXC_EN enables the exception-vector control word in EXC.
import mc_pkg::*;

module mc_out_decode (
    input  state_t state,
    input  logic   memReady,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.pcSource = PCSRC_ALU;
                ctrl.irWrite  = memReady;
                ctrl.pcWrite  = memReady;
            end
            ST_DECODE: begin
                // branch target precompute into ALUOut
                ctrl.aluSrcB = SRCB_IMM_SH2;
                ctrl.aluOp   = ALUOP_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            ST_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_B;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_B;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
            ST_ADDIWB: begin
                ctrl.regWrite = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_EXC_EN
            ST_EXC: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_EXC;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: state register and
// next-state logic. MULTICYCLE_CTRL_EXC_EN routes unknown opcodes to EXC.
import mc_pkg::*;

module multicycle_ctrl #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                memReady,
    output logic                pcWrite,
    output logic                pcWriteCond,
    output logic                iorD,
    output logic                memRead,
    output logic                memWrite,
    output logic                irWrite,
    output logic                memToReg,
    output logic                regDst,
    output logic                regWrite,
    output logic                aluSrcA,
    output logic [SEL_W-1:0]    aluSrcB,
    output logic [SEL_W-1:0]    aluOp,
    output logic [SEL_W-1:0]    pcSource,
    output logic [STATE_W-1:0]  state
);

    state_t stateQ;
    state_t stateNext;
    logic   ready;
    ctrl_t  ctrl;
    logic   unusedZero;

    // zero only qualifies pcWriteCond inside the datapath
    assign unusedZero = zero;
    assign ready      = USE_MEM_READY ? memReady : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= ST_IDLE;
        end else begin
            stateQ <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateQ;
        case (stateQ)
            ST_IDLE:   stateNext = ST_FETCH;
            ST_FETCH:  if (ready) stateNext = ST_DECODE;
            ST_DECODE: begin
                if (isMemOp(opcode)) begin
                    stateNext = ST_MEMADR;
                end else begin
                    case (opcode)
                        OP_R:    stateNext = ST_EXEC;
                        OP_BEQ:  stateNext = ST_BRANCH;
                        OP_J:    stateNext = ST_JUMP;
                        OP_ADDI: stateNext = ST_ADDIEX;
`ifdef MULTICYCLE_CTRL_EXC_EN
                        default: stateNext = ST_EXC;
`else
                        default: stateNext = ST_FETCH;
`endif
                    endcase
                end
            end
            ST_MEMADR: begin
                case (opcode)
                    OP_LW:   stateNext = ST_MEMRD;
                    OP_SW:   stateNext = ST_MEMWR;
                    default: stateNext = ST_FETCH;
                endcase
            end
            ST_MEMRD:  if (ready) stateNext = ST_MEMWB;
            ST_MEMWR:  if (ready) stateNext = ST_FETCH;
            ST_EXEC:   stateNext = ST_RWB;
            ST_ADDIEX: stateNext = ST_ADDIWB;
            ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB, ST_EXC:
                       stateNext = ST_FETCH;
            default:   stateNext = ST_IDLE;
        endcase
    end

    mc_out_decode uDecode (
        .state    (stateQ),
        .memReady (ready),
        .ctrl     (ctrl)
    );

    assign pcWrite     = ctrl.pcWrite;
    assign pcWriteCond = ctrl.pcWriteCond;
    assign iorD        = ctrl.iorD;
    assign memRead     = ctrl.memRead;
    assign memWrite    = ctrl.memWrite;
    assign irWrite     = ctrl.irWrite;
    assign memToReg    = ctrl.memToReg;
    assign regDst      = ctrl.regDst;
    assign regWrite    = ctrl.regWrite;
    assign aluSrcA     = ctrl.aluSrcA;
    assign aluSrcB     = ctrl.aluSrcB;
    assign aluOp       = ctrl.aluOp;
    assign pcSource    = ctrl.pcSource;
    assign state       = STATE_W'(stateQ);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a random
// instruction stream checked against a per-instruction state-sequence model.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;
    logic [15:0] actWord;

    int checks = 0;
    int errors = 0;
    int expSt[$];
    bit expRdy[$];

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .state(state)
    );

    assign actWord = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                      memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

    // Expected control word per state, same bit order as actWord
    function automatic logic [15:0] expWord(input int st, input bit rdy);
        logic pcW, pcWC, iod, mR, mW, irW, m2r, rd, rW, sA;
        logic [1:0] sB, op, pcS;
        {pcW, pcWC, iod, mR, mW, irW, m2r, rd, rW, sA} = '0;
        sB = 2'd0; op = 2'd0; pcS = 2'd0;
        case (st)
            1:  begin mR = 1; sB = 2'b01; irW = rdy; pcW = rdy; end
            2:  sB = 2'b11;
            3:  begin sA = 1; sB = 2'b10; end
            4:  begin mR = 1; iod = 1; end
            5:  begin rW = 1; m2r = 1; end
            6:  begin mW = 1; iod = 1; end
            7:  begin sA = 1; op = 2'b10; end
            8:  begin rW = 1; rd = 1; end
            9:  begin sA = 1; op = 2'b01; pcWC = 1; pcS = 2'b01; end
            10: begin pcW = 1; pcS = 2'b10; end
            11: begin sA = 1; sB = 2'b10; end
            12: rW = 1;
            13: begin pcW = 1; pcS = 2'b11; end
            default: ;
        endcase
        return {pcW, pcWC, iod, mR, mW, irW, m2r, rd, rW, sA, sB, op, pcS};
    endfunction

    function automatic bit isKnown(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Model: append the cycle-by-cycle state/memReady plan of one instruction
    task automatic plan(input logic [5:0] op, input int fetchWaits, input int memWaits);
        for (int i = 0; i < fetchWaits; i++) begin expSt.push_back(1); expRdy.push_back(0); end
        expSt.push_back(1); expRdy.push_back(1);
        expSt.push_back(2); expRdy.push_back(1'($urandom));
        case (op)
            6'b000000: begin expSt.push_back(7); expRdy.push_back(1'($urandom));
                             expSt.push_back(8); expRdy.push_back(1'($urandom)); end
            6'b100011: begin
                expSt.push_back(3); expRdy.push_back(1'($urandom));
                for (int i = 0; i < memWaits; i++) begin expSt.push_back(4); expRdy.push_back(0); end
                expSt.push_back(4); expRdy.push_back(1);
                expSt.push_back(5); expRdy.push_back(1'($urandom));
            end
            6'b101011: begin
                expSt.push_back(3); expRdy.push_back(1'($urandom));
                for (int i = 0; i < memWaits; i++) begin expSt.push_back(6); expRdy.push_back(0); end
                expSt.push_back(6); expRdy.push_back(1);
            end
            6'b000100: begin expSt.push_back(9);  expRdy.push_back(1'($urandom)); end
            6'b000010: begin expSt.push_back(10); expRdy.push_back(1'($urandom)); end
            6'b001000: begin expSt.push_back(11); expRdy.push_back(1'($urandom));
                             expSt.push_back(12); expRdy.push_back(1'($urandom)); end
            default: if (EXC_EN) begin expSt.push_back(13); expRdy.push_back(1'($urandom)); end
        endcase
    endtask

    task automatic test_reset;
        rst_n = 0; memReady = 1; opcode = 6'b000000; zero = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (state !== 4'd0 || actWord !== 16'd0) begin errors++;
            $display("FAIL reset_hold: state=%0d word=%h, required state=0 word=0000", state, actWord); end
        rst_n = 1; #1;
        checks++; if (state !== 4'd0) begin errors++;
            $display("FAIL reset_release_idle: state=%0d, required 0", state); end
        @(posedge clk); #1;
        checks++; if (state !== 4'd1) begin errors++;
            $display("FAIL reset_to_fetch: state=%0d, required 1", state); end
        opcode = 6'b101011;
        repeat (2) @(posedge clk);
        #1; memReady = 0;
        @(posedge clk); #1;
        checks++; if (state !== 4'd6 || memWrite !== 1'b1) begin errors++;
            $display("FAIL reset_reach_memwr: state=%0d memWrite=%b, required 6/1", state, memWrite); end
        #2 rst_n = 0; #1;
        checks++; if (state !== 4'd0 || memWrite !== 1'b0 || actWord !== 16'd0) begin errors++;
            $display("FAIL reset_abort_memwr: state=%0d memWrite=%b word=%h, required 0/0/0000", state, memWrite, actWord); end
        @(posedge clk); #1;
        rst_n = 1; memReady = 1; #1;
        checks++; if (state !== 4'd0) begin errors++;
            $display("FAIL reset_abort_idle: state=%0d, required 0", state); end
        @(posedge clk); #1;
        checks++; if (state !== 4'd1) begin errors++;
            $display("FAIL reset_abort_fetch: state=%0d, required 1", state); end
    endtask

    task automatic test_rtype;
        int seq[5] = '{1, 2, 7, 8, 1};
        opcode = 6'b000000; memReady = 1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state !== 4'(seq[i])) begin errors++;
                $display("FAIL rtype_state[%0d]: state=%0d, required %0d", i, state, seq[i]); end
            if (i == 2) begin checks++; if (aluOp !== 2'b10) begin errors++;
                $display("FAIL rtype_exec_aluop: aluOp=%b, required 10", aluOp); end end
            if (i == 3) begin checks++; if (regWrite !== 1'b1 || regDst !== 1'b1 || memToReg !== 1'b0) begin errors++;
                $display("FAIL rtype_rwb: regWrite=%b regDst=%b memToReg=%b, required 1/1/0", regWrite, regDst, memToReg); end end
            if (i < 4) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_lw_waits;
        int seq[8] = '{1, 2, 3, 4, 4, 4, 5, 1};
        opcode = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            memReady = !(i == 3 || i == 4);
            #1;
            checks++; if (state !== 4'(seq[i])) begin errors++;
                $display("FAIL lw_state[%0d]: state=%0d, required %0d", i, state, seq[i]); end
            if (seq[i] == 4) begin checks++; if (memRead !== 1'b1 || iorD !== 1'b1) begin errors++;
                $display("FAIL lw_memrd[%0d]: memRead=%b iorD=%b, required 1/1", i, memRead, iorD); end end
            checks++; if (regWrite !== (seq[i] == 5) || memToReg !== (seq[i] == 5)) begin errors++;
                $display("FAIL lw_wb[%0d]: regWrite=%b memToReg=%b, required %b", i, regWrite, memToReg, seq[i] == 5); end
            if (i < 7) begin @(posedge clk); #1; end
        end
        memReady = 1;
    endtask

    task automatic test_beq;
        int seq[4] = '{1, 2, 9, 1};
        opcode = 6'b000100; memReady = 1;
        for (int i = 0; i < 4; i++) begin
            zero = 1'($urandom); #1;
            checks++; if (state !== 4'(seq[i])) begin errors++;
                $display("FAIL beq_state[%0d]: state=%0d, required %0d", i, state, seq[i]); end
            if (i == 2) begin checks++;
                if (pcWriteCond !== 1'b1 || aluOp !== 2'b01 || pcSource !== 2'b01 || pcWrite !== 1'b0) begin errors++;
                $display("FAIL beq_branch: pcWriteCond=%b aluOp=%b pcSource=%b pcWrite=%b, required 1/01/01/0",
                         pcWriteCond, aluOp, pcSource, pcWrite); end end
            if (i < 3) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_fetch_stall;
        int seq[7] = '{1, 1, 1, 1, 2, 10, 1};
        int strobes = 0;
        opcode = 6'b000010;
        for (int i = 0; i < 7; i++) begin
            memReady = (i >= 3); #1;
            checks++; if (state !== 4'(seq[i])) begin errors++;
                $display("FAIL stall_state[%0d]: state=%0d, required %0d", i, state, seq[i]); end
            if (i < 4) begin
                if (irWrite === 1'b1) strobes++;
                checks++; if (irWrite !== (i == 3) || pcWrite !== (i == 3)) begin errors++;
                    $display("FAIL stall_strobe[%0d]: irWrite=%b pcWrite=%b, required %b", i, irWrite, pcWrite, i == 3); end
            end
            if (i < 6) begin @(posedge clk); #1; end
        end
        checks++; if (strobes != 1) begin errors++;
            $display("FAIL stall_strobe_count: irWrite pulses=%0d, required 1", strobes); end
    endtask

    task automatic test_unknown;
        int seq[4];
        int n;
        if (EXC_EN) begin seq = '{1, 2, 13, 1}; n = 4; end
        else        begin seq = '{1, 2, 1, 0};  n = 3; end
        opcode = 6'b111111; memReady = 1;
        for (int i = 0; i < n; i++) begin
            #1;
            checks++; if (state !== 4'(seq[i])) begin errors++;
                $display("FAIL unknown_state[%0d]: state=%0d, required %0d", i, state, seq[i]); end
            checks++; if ((pcSource === 2'b11) !== (seq[i] == 13)) begin errors++;
                $display("FAIL unknown_pcsource[%0d]: pcSource=%b in state %0d", i, pcSource, state); end
            if (seq[i] == 13) begin checks++; if (pcWrite !== 1'b1) begin errors++;
                $display("FAIL unknown_exc_pcwrite: pcWrite=%b, required 1", pcWrite); end end
            if (i < n - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_random;
        logic [5:0] op;
        int st;
        bit rdy;
        int cyc = 0;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                default: begin op = 6'($urandom); while (isKnown(op)) op = 6'($urandom); end
            endcase
            opcode = op;
            plan(op, $urandom_range(0, 2), $urandom_range(0, 3));
            while (expSt.size() > 0) begin
                st = expSt.pop_front(); rdy = expRdy.pop_front();
                memReady = rdy; zero = 1'($urandom); #1;
                checks++; if (state !== 4'(st)) begin errors++;
                    $display("FAIL random_state cyc %0d op %b: state=%0d, required %0d", cyc, op, state, st); end
                checks++; if (actWord !== expWord(st, rdy)) begin errors++;
                    $display("FAIL random_ctrl cyc %0d state %0d: word=%h, required %h", cyc, st, actWord, expWord(st, rdy)); end
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_waits();
        test_beq();
        test_fetch_stall();
        test_unknown();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
